// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants and types for the instruction memory loader
package imem_pkg;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {
    EMPTY,
    LOAD,
    RUN
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_RANGE    = 2'd2;
  localparam logic [1:0] ERR_EMPTY    = 2'd3;

endpackage

// File: rtl/imem_flash_loader_if.sv
// rtl/imem_flash_loader_if.sv - flash load and fetch signal bundle for imem_flash_loader
interface imem_flash_loader_if #(
  parameter int DEPTH_BYTES = 1024,
  parameter int FLASH_BYTES = 1,
  parameter int PC_W        = 64
);
  localparam int LW = $clog2(DEPTH_BYTES) + 1;

  logic                     flashEn;
  logic                     flashValid;
  logic [8*FLASH_BYTES-1:0] flashData;
  logic                     flashReady;
  logic                     flashOverflow;
  logic [LW-1:0]            loadedBytes;
  logic                     fetchReq;
  logic                     stall;
  logic [PC_W-1:0]          pc;
  logic                     instrValid;
  logic [31:0]              instruction;
  logic [PC_W-1:0]          pcBypass;
  logic                     fetchErr;

  modport master (
    output flashEn, flashValid, flashData, fetchReq, stall, pc,
    input  flashReady, flashOverflow, loadedBytes, instrValid, instruction, pcBypass, fetchErr
  );

  modport slave (
    input  flashEn, flashValid, flashData, fetchReq, stall, pc,
    output flashReady, flashOverflow, loadedBytes, instrValid, instruction, pcBypass, fetchErr
  );

endinterface

// File: rtl/imem_byte_ram.sv
// rtl/imem_byte_ram.sv - byte-addressed storage with byte-lane write and 32-bit registered read
module imem_byte_ram #(
  parameter int DEPTH_BYTES = 1024,
  parameter int FLASH_BYTES = 1,
  localparam int AW         = $clog2(DEPTH_BYTES)
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [AW-1:0]            waddr,
  input  logic [8*FLASH_BYTES-1:0] wdata,
  input  logic                     re,
  input  logic [AW-1:0]            raddr,
  output logic [31:0]              rdata
);

  logic [7:0] mem [DEPTH_BYTES];

  // Contents are intentionally not reset; rdata only updates on a checked read.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < FLASH_BYTES; i++) begin
        mem[waddr + AW'(i)] <= wdata[8*i +: 8];
      end
    end
    if (re) begin
      rdata <= {mem[raddr + AW'(3)], mem[raddr + AW'(2)], mem[raddr + AW'(1)], mem[raddr]};
    end
  end

endmodule

// File: rtl/imem_flash_loader.sv
// rtl/imem_flash_loader.sv - flash-loaded instruction memory with one-cycle registered fetch
module imem_flash_loader
  import imem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int FLASH_BYTES = 1,
  parameter int PC_W        = 64
) (
  input  logic                clk,
  input  logic                rstN,
  imem_flash_loader_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int LW = AW + 1;
  localparam int EW = PC_W + 1;

  state_t          state;
  logic [LW-1:0]   wptr;
  logic            ovf_q;
  logic            iv_q;
  logic            err_q;
  logic            nop_q;
  logic [PC_W-1:0] pcb_q;
  logic [31:0]     rd_word;
  logic [1:0]      cause;
  logic [EW-1:0]   pc_end;
  logic            ready;
  logic            fetch_err;
  logic            capture;
  logic            wr_en;

  assign ready = (state == LOAD) &&
                 ((LW+1)'(wptr) + (LW+1)'(FLASH_BYTES) <= (LW+1)'(DEPTH_BYTES));

  // End address is one bit wider than pc so a fetch near the top cannot wrap into range.
  assign pc_end = {1'b0, bus.pc} + EW'(4);

  always_comb begin
    cause = ERR_NONE;
    if (state == EMPTY) begin
      cause = ERR_EMPTY;
    end else if (bus.pc[1:0] != 2'b00) begin
      cause = ERR_MISALIGN;
    end else if (pc_end > EW'(wptr)) begin
      cause = ERR_RANGE;
    end
  end

  assign fetch_err = (cause != ERR_NONE);
  assign capture   = (state != LOAD) && !bus.flashEn && !bus.stall && bus.fetchReq;
  assign wr_en     = (state == LOAD) && bus.flashEn && bus.flashValid && ready;

  imem_byte_ram #(
    .DEPTH_BYTES(DEPTH_BYTES),
    .FLASH_BYTES(FLASH_BYTES)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wptr[AW-1:0]),
    .wdata(bus.flashData),
    .re   (capture && !fetch_err),
    .raddr(bus.pc[AW-1:0]),
    .rdata(rd_word)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= EMPTY;
      wptr  <= '0;
      ovf_q <= 1'b0;
      iv_q  <= 1'b0;
      err_q <= 1'b0;
      nop_q <= 1'b1;
      pcb_q <= '0;
    end else begin
      case (state)
        EMPTY, RUN: begin
          if (bus.flashEn) begin
            state <= LOAD;
            wptr  <= '0;
            ovf_q <= 1'b0;
            iv_q  <= 1'b0;
            err_q <= 1'b0;
          end else if (!bus.stall) begin
            if (bus.fetchReq) begin
              iv_q  <= 1'b1;
              err_q <= fetch_err;
              nop_q <= fetch_err;
              pcb_q <= bus.pc;
            end else begin
              iv_q <= 1'b0;
            end
          end
        end
        LOAD: begin
          if (!bus.flashEn) begin
            state <= RUN;
          end else if (bus.flashValid) begin
            if (ready) begin
              wptr <= wptr + LW'(FLASH_BYTES);
            end else begin
              ovf_q <= 1'b1;
            end
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign bus.flashReady    = ready;
  assign bus.flashOverflow = ovf_q;
  assign bus.loadedBytes   = wptr;
  assign bus.instrValid    = iv_q;
  assign bus.instruction   = nop_q ? NOP : rd_word;
  assign bus.pcBypass      = pcb_q;
  assign bus.fetchErr      = err_q;

endmodule

// File: tb/tb_imem_flash_loader.sv
// tb/tb_imem_flash_loader.sv - self-checking bench for imem_flash_loader
module tb_imem_flash_loader;

  localparam int DEPTH = 8;
  localparam int FB    = 1;
  localparam logic [31:0] NOPW = 32'h00000013;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  imem_flash_loader_if #(.DEPTH_BYTES(DEPTH), .FLASH_BYTES(FB), .PC_W(64)) bus ();

  imem_flash_loader #(.DEPTH_BYTES(DEPTH), .FLASH_BYTES(FB), .PC_W(64)) dut (
    .clk (clk),
    .rstN(rstN),
    .bus (bus)
  );

  // Behavioural model: mode 0=empty, 1=loading, 2=running.
  int          m_mode;
  logic [7:0]  m_mem [DEPTH];
  int          m_ptr;
  bit          m_ovf;
  bit          m_iv;
  bit          m_err;
  logic [31:0] m_instr;
  logic [63:0] m_pcb;

  initial for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;

  always @(posedge clk or negedge rstN) begin
    logic [64:0] fetch_end;
    int          a;
    if (!rstN) begin
      m_mode = 0; m_ptr = 0; m_ovf = 0; m_iv = 0; m_err = 0; m_instr = NOPW; m_pcb = '0;
    end else if (bus.flashEn && m_mode != 1) begin
      m_mode = 1; m_ptr = 0; m_ovf = 0; m_iv = 0; m_err = 0;
    end else if (m_mode == 1) begin
      if (!bus.flashEn) m_mode = 2;
      else if (bus.flashValid) begin
        if (m_ptr + FB <= DEPTH) begin
          for (int k = 0; k < FB; k++) m_mem[m_ptr + k] = bus.flashData[8*k +: 8];
          m_ptr = m_ptr + FB;
        end else m_ovf = 1;
      end
    end else if (!bus.stall) begin
      if (bus.fetchReq) begin
        fetch_end = {1'b0, bus.pc} + 65'd4;
        m_iv  = 1;
        m_pcb = bus.pc;
        m_err = (m_mode == 0) || (bus.pc % 4 != 0) || (fetch_end > 65'(m_ptr));
        if (m_err) m_instr = NOPW;
        else begin
          a = int'(bus.pc);
          m_instr = {m_mem[a+3], m_mem[a+2], m_mem[a+1], m_mem[a]};
        end
      end else m_iv = 0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstN) begin
      chk("m_flashReady", 64'(bus.flashReady), 64'((m_mode == 1) && (m_ptr + FB <= DEPTH)));
      chk("m_flashOverflow", 64'(bus.flashOverflow), 64'(m_ovf));
      chk("m_loadedBytes", 64'(bus.loadedBytes), 64'(m_ptr));
      chk("m_instrValid", 64'(bus.instrValid), 64'(m_iv));
      chk("m_instruction", 64'(bus.instruction), 64'(m_instr));
      chk("m_pcBypass", bus.pcBypass, m_pcb);
      chk("m_fetchErr", 64'(bus.fetchErr), 64'(m_err));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [63:0] addr);
    bus.fetchReq = 1'b1;
    bus.pc = addr;
    step();
  endtask

  task automatic beat(input logic [7:0] d);
    bus.flashValid = 1'b1;
    bus.flashData = d;
    step();
    bus.flashValid = 1'b0;
  endtask

  initial begin
    logic [7:0] prog [8];
    prog = '{8'h83, 8'h30, 8'h00, 8'h00, 8'h03, 8'h31, 8'h80, 8'h00};
    bus.flashEn = 0; bus.flashValid = 0; bus.flashData = '0;
    bus.fetchReq = 0; bus.stall = 0; bus.pc = '0;
    repeat (3) step();
    rstN = 1'b1;
    step();
    chk("rst_instrValid", 64'(bus.instrValid), 64'd0);
    chk("rst_instruction", 64'(bus.instruction), 64'(NOPW));
    chk("rst_pcBypass", bus.pcBypass, 64'd0);
    chk("rst_fetchErr", 64'(bus.fetchErr), 64'd0);
    chk("rst_flashReady", 64'(bus.flashReady), 64'd0);
    chk("rst_loadedBytes", 64'(bus.loadedBytes), 64'd0);

    fetch(64'd0);
    chk("empty_valid", 64'(bus.instrValid), 64'd1);
    chk("empty_err", 64'(bus.fetchErr), 64'd1);
    chk("empty_nop", 64'(bus.instruction), 64'(NOPW));
    bus.fetchReq = 0;

    bus.flashEn = 1; step();
    chk("load_ready_first", 64'(bus.flashReady), 64'd1);
    for (int i = 0; i < 8; i++) beat(prog[i]);
    bus.flashEn = 0; step();
    chk("prog_loaded", 64'(bus.loadedBytes), 64'd8);

    fetch(64'd0);
    chk("f0_instr", 64'(bus.instruction), 64'h00003083);
    chk("f0_pc", bus.pcBypass, 64'd0);
    fetch(64'd4);
    chk("f4_instr", 64'(bus.instruction), 64'h00803103);
    chk("f4_pc", bus.pcBypass, 64'd4);
    chk("f4_valid", 64'(bus.instrValid), 64'd1);
    fetch(64'd2);
    chk("mis_err", 64'(bus.fetchErr), 64'd1);
    chk("mis_nop", 64'(bus.instruction), 64'(NOPW));
    fetch(64'd8);
    chk("range_err", 64'(bus.fetchErr), 64'd1);
    bus.fetchReq = 0; step();
    chk("idle_valid", 64'(bus.instrValid), 64'd0);

    fetch(64'd0);
    bus.stall = 1; bus.pc = 64'd4; step();
    chk("stall_instr", 64'(bus.instruction), 64'h00003083);
    chk("stall_pc", bus.pcBypass, 64'd0);
    step();
    chk("stall2_instr", 64'(bus.instruction), 64'h00003083);
    bus.stall = 0; step();
    chk("unstall_instr", 64'(bus.instruction), 64'h00803103);
    bus.fetchReq = 0; step();

    bus.flashEn = 1; step();
    beat(8'h13); beat(8'h05); beat(8'h10); beat(8'h00);
    bus.flashEn = 0; bus.flashValid = 1; bus.flashData = 8'hEE; step();
    bus.flashValid = 0;
    chk("partial_loaded", 64'(bus.loadedBytes), 64'd4);
    fetch(64'd4);
    chk("partial_range_err", 64'(bus.fetchErr), 64'd1);
    fetch(64'd0);
    chk("partial_instr", 64'(bus.instruction), 64'h00100513);
    bus.fetchReq = 0; step();

    bus.flashEn = 1; bus.fetchReq = 1; bus.pc = 64'd0; step();
    chk("flash_wins_valid", 64'(bus.instrValid), 64'd0);
    bus.fetchReq = 0;
    for (int i = 0; i < 8; i++) beat(8'h10 + 8'(i));
    chk("full_ready", 64'(bus.flashReady), 64'd0);
    beat(8'h18);
    chk("ovf_set", 64'(bus.flashOverflow), 64'd1);
    chk("ovf_loaded", 64'(bus.loadedBytes), 64'd8);
    bus.flashEn = 0; step();
    fetch(64'd4);
    chk("ovf_f4", 64'(bus.instruction), 64'h17161514);
    fetch(64'd0);
    chk("ovf_byte0", 64'(bus.instruction), 64'h13121110);
    bus.fetchReq = 0; step();

    bus.flashEn = 1; step();
    beat(8'hA1); beat(8'hA2); beat(8'hA3);
    rstN = 1'b0;
    #2;
    chk("midrst_loaded", 64'(bus.loadedBytes), 64'd0);
    chk("midrst_ready", 64'(bus.flashReady), 64'd0);
    bus.flashEn = 0; bus.flashValid = 0;
    step();
    rstN = 1'b1;
    step();
    fetch(64'd0);
    chk("midrst_err", 64'(bus.fetchErr), 64'd1);
    chk("midrst_valid", 64'(bus.instrValid), 64'd1);
    bus.fetchReq = 0;
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_flash_loader.md
# imem_flash_loader

Parametrised, clocked instruction memory for the single-cycle/pipelined RISC-V datapath, replacing the combinational byte-array fetch stage. It holds a little-endian byte-addressed program image, loads it through a flash port with an auto-incrementing write pointer, and serves 32-bit fetches with one-cycle registered latency. It sits between the PC register and the decode stage, passing the fetched PC downstream alongside the instruction.

## Interface
- DEPTH_BYTES, 1024: memory size in bytes; power of two, ≥ 8.
- FLASH_BYTES, 1: bytes written per flash beat (1, 2 or 4).
- PC_W, 64: program counter width.
- clk  in  1  single clock, rising edge.
- rstN  in  1  asynchronous, active-low reset.
- flashEn  in  1  load mode request; level-sensitive.
- flashValid  in  1  flashData beat valid.
- flashData  in  8*FLASH_BYTES  beat payload, lowest byte at lowest address.
- flashReady  out  1  beat accepted this cycle when flashValid=1.
- flashOverflow  out  1  sticky: beat offered after memory full.
- loadedBytes  out  $clog2(DEPTH_BYTES)+1  bytes written in last load.
- fetchReq  in  1  fetch request for pc.
- stall  in  1  hold fetch outputs.
- pc  in  PC_W  fetch byte address.
- instrValid  out  1  instruction/pcBypass valid.
- instruction  out  32  fetched word, {mem[pc+3],mem[pc+2],mem[pc+1],mem[pc]}.
- pcBypass  out  PC_W  pc belonging to instruction.
- fetchErr  out  1  misaligned, out-of-range, or no program loaded.

## Operation
- States: EMPTY (reset), LOAD, RUN.
- EMPTY→LOAD and RUN→LOAD when flashEn=1: write pointer cleared to 0, loadedBytes cleared, flashOverflow cleared, instrValid forced 0.
- LOAD: flashReady=1 while pointer + FLASH_BYTES ≤ DEPTH_BYTES; accepted beat writes FLASH_BYTES bytes at pointer, pointer += FLASH_BYTES, loadedBytes tracks pointer. When full: flashReady=0, no wrap, beat with flashValid=1 sets flashOverflow.
- LOAD→RUN when flashEn=0 (beat on the same cycle is not written).
- RUN: fetchReq=1 and stall=0 captures a fetch; result is registered next cycle. Error if pc[1:0]≠0, or pc+4 > loadedBytes (computed in PC_W+1 bits, no wrap). On error: instruction=32'h00000013 (NOP), fetchErr=1, instrValid=1.
- Fetch in EMPTY: NOP, fetchErr=1, instrValid=1. Fetch in LOAD: ignored.
- stall=1: instruction, pcBypass, instrValid, fetchErr hold; fetchReq ignored.
- fetchReq=0, stall=0: instrValid=0 next cycle; instruction/pcBypass hold last value.
- flashEn and fetchReq in the same cycle: flash wins, fetch dropped.
- Memory contents are not reset; read never returns X to downstream logic (pre-load reads are blocked by loadedBytes check).

## Timing
- Reset values: state EMPTY, flashReady 0, flashOverflow 0, loadedBytes 0, instrValid 0, instruction 32'h00000013, pcBypass 0, fetchErr 0.
- Reset asserted mid-load: load aborts immediately, state EMPTY, loadedBytes 0.
- flashReady is combinational from state and pointer; valid in the first LOAD cycle (cycle after flashEn seen).
- Fetch latency: 1 cycle, fetchReq at edge N → instrValid at edge N+1.
- Back-to-back fetches: one per cycle, no bubbles.
- Write in LOAD and read of the same byte cannot collide (reads blocked in LOAD).

## Structure
- Package imem_pkg: NOP constant 32'h00000013, state enum {EMPTY, LOAD, RUN}, error-cause localparams.
- Sub-module imem_byte_ram: DEPTH_BYTES×8 storage, FLASH_BYTES-wide byte-lane write port, 4-byte little-endian registered read port with wrap-free addressing.
- Top: FSM, write pointer, loadedBytes, fetch range/alignment check, output hold registers.

## Test plan
- Reset, then fetchReq with pc=0 → instrValid=1, fetchErr=1, instruction=32'h00000013 one cycle later.
- FLASH_BYTES=1: load bytes 83 30 00 00 03 31 80 00, drop flashEn, fetch pc=0 then pc=4 back-to-back → 32'h00003083 then 32'h00803103, pcBypass 0 then 4, loadedBytes=8.
- After same load: fetch pc=2 → fetchErr=1 (misaligned); fetch pc=8 → fetchErr=1 (beyond loadedBytes); both NOP.
- DEPTH_BYTES=8: offer 9 beats → flashReady low after 8th, flashOverflow=1, loadedBytes=8, byte 0 unchanged.
- Fetch pc=0 with stall=1 on following cycle and new pc=4 requested → outputs hold 32'h00003083 until stall drops.
- Assert rstN low mid-load after 3 bytes → state EMPTY, loadedBytes=0, subsequent fetch returns fetchErr=1.
